sia_wbx: RTL

- Parametrised next-generation Wishbone B.4 pipelined slave for the SIA serial core.
- Exposes the configuration, status, interrupt-enable, bit-rate and data-queue registers to a 16-bit bus master.
- Compared with the fixed 16-bit register port it adds:
  - configurable character width and bit-rate width;
  - optional back-pressure (stall) on full or empty queues;
  - byte-lane assembly of transmit words;
  - a sticky receive-overrun flag;
  - a registered interrupt request.
- Sits between the bus interconnect and the SIA transmitter/receiver queues.

---
 rtl/sia_wbx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sia_wbx.sv
// sia_wbx - Wishbone B.4 pipelined slave for the SIA serial core.
//
// Exposes STATUS, CONFIG, INTENA, TRXDAT and the bit-rate divisor to a
// 16-bit bus master. Register writes take effect on the accepting edge.
// ack_o and the queue strobes (txq_we_o, rxq_pop_o, rxq_oe_o) are
// registered, so they appear one cycle after acceptance.
//
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   adr_i, we_i, cyc_i, stb_i   bus request (word address [3:1])
//   dat_i, sel_i                write data and byte lane selects
//   dat_o, ack_o, stall_o       read data, acknowledge, back-pressure
//   bits_o..bitrat_o            configuration outputs to the serial core
//   irq_o                       registered interrupt request
//   rxq_*                       receive queue head, status and pop/oe
//   txq_*                       transmit queue push, data and status
module sia_wbx #(
  parameter int CW         = 16,
  parameter int BRW        = 20,
  parameter int BITRAT_RST = 83332,
  parameter int STALL_TX   = 1,
  parameter int STALL_RX   = 0
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [2:0]     adr_i,
  input  logic           we_i,
  input  logic           cyc_i,
  input  logic           stb_i,
  input  logic [15:0]    dat_i,
  input  logic [1:0]     sel_i,
  output logic [15:0]    dat_o,
  output logic           ack_o,
  output logic           stall_o,
  output logic [4:0]     bits_o,
  output logic           eedc_o,
  output logic           eedd_o,
  output logic [2:0]     txcmod_o,
  output logic           rxcpol_o,
  output logic [4:0]     intena_o,
  output logic [BRW-1:0] bitrat_o,
  output logic           irq_o,
  output logic           rxq_pop_o,
  output logic           rxq_oe_o,
  input  logic [CW-1:0]  rxq_dat_i,
  input  logic           rxq_full_i,
  input  logic           rxq_not_empty_i,
  input  logic           rxq_push_i,
  output logic           txq_we_o,
  output logic [CW-1:0]  txq_dat_o,
  input  logic           txq_not_full_i,
  input  logic           txq_empty_i,
  input  logic           txq_idle_i
);

  localparam logic [2:0] A_STATUS = 3'd0, A_CONFIG = 3'd1, A_INTENA = 3'd2,
                         A_TRXDAT = 3'd3, A_BR_LO  = 3'd4, A_BR_HI  = 3'd5;

  logic        req, is_trx, tx_commit_req, rx_read_req;
  logic        accept, wr, rd;
  logic        ack_r, pop_r, txq_we_r, rxovr, hold_v;
  logic [7:0]  hold;
  logic [15:0] rdat_r, rd_mux, status, cfg_rd, commit_w;
  logic [31:0] br32;

  assign req           = cyc_i & stb_i;
  assign is_trx        = (adr_i == A_TRXDAT);
  // sel_i[1] set means the write completes a word (sel 10 or 11)
  assign tx_commit_req = req & we_i & is_trx & sel_i[1];
  assign rx_read_req   = req & ~we_i & is_trx;

  assign stall_o = ~reset_i &
                   (((STALL_TX != 0) & tx_commit_req & ~txq_not_full_i) |
                    ((STALL_RX != 0) & rx_read_req & ~rxq_not_empty_i));

  assign accept = req & ~stall_o;
  assign wr     = accept & we_i;
  assign rd     = accept & ~we_i;

  assign status = {rxq_not_empty_i, rxq_full_i, rxovr, 8'h00, irq_o, 1'b0,
                   txq_idle_i, txq_not_full_i, txq_empty_i};
  assign cfg_rd = {2'b00, rxcpol_o, txcmod_o, eedc_o, eedd_o, 3'b000, bits_o};
  assign br32   = 32'(bitrat_o);

  // Low byte comes from this write when its lane is selected, otherwise
  // from the hold register (0 if nothing was staged).
  assign commit_w = {dat_i[15:8], sel_i[0] ? dat_i[7:0] : (hold_v ? hold : 8'h00)};

  always_comb begin
    rd_mux = 16'h0000;
    case (adr_i)
      A_STATUS: rd_mux = status;
      A_CONFIG: rd_mux = cfg_rd;
      A_INTENA: rd_mux = {11'h000, intena_o};
      A_BR_LO:  rd_mux = br32[15:0];
      A_BR_HI:  rd_mux = br32[31:16];
      default:  rd_mux = 16'h0000;  // TRXDAT uses the live queue head
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ack_r     <= 1'b0;
      pop_r     <= 1'b0;
      txq_we_r  <= 1'b0;
      rdat_r    <= 16'h0000;
      bits_o    <= 5'd10;
      eedc_o    <= 1'b1;
      eedd_o    <= 1'b1;
      txcmod_o  <= 3'b100;
      rxcpol_o  <= 1'b0;
      intena_o  <= 5'h00;
      bitrat_o  <= BRW'(BITRAT_RST);
      txq_dat_o <= '0;
      hold      <= 8'h00;
      hold_v    <= 1'b0;
      rxovr     <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      ack_r    <= accept;
      rdat_r   <= rd ? rd_mux : 16'h0000;
      pop_r    <= rd & is_trx & rxq_not_empty_i;
      txq_we_r <= wr & is_trx & sel_i[1] & txq_not_full_i;

      if (wr) begin
        case (adr_i)
          A_CONFIG: begin
            if (sel_i[0]) bits_o <= dat_i[4:0];
            if (sel_i[1]) {rxcpol_o, txcmod_o, eedc_o, eedd_o} <= dat_i[13:8];
          end
          A_INTENA: if (sel_i[0]) intena_o <= dat_i[4:0];
          A_TRXDAT: begin
            if (sel_i == 2'b01) begin
              hold   <= dat_i[7:0];
              hold_v <= 1'b1;
            end else if (sel_i[1]) begin
              // a commit into a full queue (non-stalling build) is dropped
              hold_v <= 1'b0;
              if (txq_not_full_i) txq_dat_o <= commit_w[CW-1:0];
            end
          end
          default: ;
        endcase
      end

      // bitrat bit i lives at address 4 + i/16, byte lane (i/8)%2
      if (wr && (adr_i == A_BR_LO || adr_i == A_BR_HI)) begin
        for (int i = 0; i < BRW; i++) begin
          if (adr_i[0] == 1'(i / 16) && sel_i[(i / 8) % 2])
            bitrat_o[i] <= dat_i[i % 16];
        end
      end

      // set wins over a simultaneous write-1-to-clear
      if (rxq_push_i && rxq_full_i)
        rxovr <= 1'b1;
      else if (wr && adr_i == A_STATUS && sel_i[1] && dat_i[13])
        rxovr <= 1'b0;

      irq_o <= |(intena_o & {rxovr, txq_idle_i, txq_empty_i, rxq_full_i, rxq_not_empty_i});
    end
  end

  // Dropping cyc_i abandons the cycle: no ack and no queue strobe.
  assign ack_o     = ack_r & cyc_i;
  assign rxq_pop_o = pop_r & cyc_i;
  assign rxq_oe_o  = pop_r & cyc_i;
  assign txq_we_o  = txq_we_r & cyc_i;
  assign dat_o     = ack_o ? (pop_r ? 16'(rxq_dat_i) : rdat_r) : 16'h0000;

endmodule
